// File: rtl/ep_out_txn_ctrl_pkg.sv
// Shared constants for the endpoint OUT/SETUP transaction controller:
// PID codes, packet field positions and the controller state encoding.
package ep_pkg;

  localparam logic [7:0] PID_SETUP = 8'h2D;
  localparam logic [7:0] PID_OUT   = 8'hE1;
  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;
  localparam logic [7:0] PID_ACK   = 8'hD2;
  localparam logic [7:0] PID_NAK   = 8'h5A;
  localparam logic [7:0] PID_STALL = 8'h1E;

  // Bit 88 of the incoming packet is reserved; only [87:0] is ever stored.
  localparam int PKT_W      = 89;
  localparam int PKT_RSVD   = 88;
  localparam int PKT_PID_HI = 87;
  localparam int PKT_PID_LO = 80;
  localparam int PKT_PAY_HI = 79;
  localparam int PKT_PAY_LO = 16;
  localparam int PKT_CRC_HI = 15;
  localparam int PKT_CRC_LO = 0;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_DATA = 2'd1,
    ST_CHECK     = 2'd2,
    ST_HANDSHAKE = 2'd3
  } ep_state_e;

  function automatic logic pid_is_data(input logic [7:0] pid);
    return (pid == PID_DATA0) || (pid == PID_DATA1);
  endfunction

endpackage

// File: rtl/ep_out_txn_ctrl_if.sv
// Signal bundle between the deserializer/buffer/transmitter side (master)
// and the transaction controller (slave).
interface ep_out_txn_if;
  import ep_pkg::*;

  logic             token_valid;
  logic [7:0]       token_pid;
  logic             pkt_valid;
  logic [PKT_W-1:0] packet;
  logic             ep_stall;
  logic             buf_ready;
  logic             buf_wr;
  logic [63:0]      buf_data;
  logic             setup_valid;
  logic [63:0]      setup_data;
  // hs_valid/hs_pid stay stable until the cycle hs_ready is high; the
  // handshake transfers in that cycle. token/pkt/buf/setup are plain strobes.
  logic             hs_valid;
  logic [7:0]       hs_pid;
  logic             hs_ready;
  logic             data_error;
  logic             timeout_err;
  logic             toggle;
  logic             busy;
  ep_state_e        state;

  modport master (
    output token_valid, token_pid, pkt_valid, packet, ep_stall, buf_ready, hs_ready,
    input  buf_wr, buf_data, setup_valid, setup_data, hs_valid, hs_pid,
           data_error, timeout_err, toggle, busy, state
  );

  modport slave (
    input  token_valid, token_pid, pkt_valid, packet, ep_stall, buf_ready, hs_ready,
    output buf_wr, buf_data, setup_valid, setup_data, hs_valid, hs_pid,
           data_error, timeout_err, toggle, busy, state
  );

endinterface

// File: rtl/ep_out_txn_ctrl_crc16.sv
// Combinational CRC16 (x^16 + x^15 + x^2 + 1) over 64 data bits,
// Data[63] shifted in first.
module CRC16_D64 (
  input  logic [63:0] Data,
  input  logic [15:0] crc,
  output logic [15:0] nextCRC16_D64
);

  logic [15:0] c;

  always_comb begin
    c = crc;
    for (int i = 63; i >= 0; i--) begin
      if (c[15] ^ Data[i]) c = {c[14:0], 1'b0} ^ 16'h8005;
      else                 c = {c[14:0], 1'b0};
    end
    nextCRC16_D64 = c;
  end

endmodule

// File: rtl/ep_out_txn_ctrl.sv
// Receive-side transaction sequencer for one endpoint: token, data packet,
// CRC/toggle check, buffer or SETUP write, then ACK/NAK/STALL handshake.
module ep_out_txn_ctrl
  import ep_pkg::*;
#(
  parameter int          TIMEOUT  = 32,
  parameter logic [15:0] CRC_INIT = 16'h0000
) (
  input logic         clk,
  input logic         reset,
  ep_out_txn_if.slave bus
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  ep_state_e   state_q, state_d;
  logic        is_setup_q, is_setup_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [87:0] pkt_q, pkt_d;
  logic        toggle_q, toggle_d;
  logic        hs_valid_q, hs_valid_d;
  logic [7:0]  hs_pid_q, hs_pid_d;
  logic        buf_wr_q, buf_wr_d;
  logic [63:0] buf_data_q, buf_data_d;
  logic        setup_valid_q, setup_valid_d;
  logic [63:0] setup_data_q, setup_data_d;
  logic        data_error_q, data_error_d;
  logic        timeout_err_q, timeout_err_d;

  logic [7:0]  rx_pid;
  logic [63:0] rx_payload;
  logic [15:0] rx_crc;
  logic [15:0] calc_crc;
  logic        rx_toggle;
  logic        unused_rsvd;

  assign rx_pid      = pkt_q[PKT_PID_HI:PKT_PID_LO];
  assign rx_payload  = pkt_q[PKT_PAY_HI:PKT_PAY_LO];
  assign rx_crc      = pkt_q[PKT_CRC_HI:PKT_CRC_LO];
  assign rx_toggle   = (rx_pid == PID_DATA1);
  assign unused_rsvd = bus.packet[PKT_RSVD];

  CRC16_D64 u_crc (
    .Data          (rx_payload),
    .crc           (CRC_INIT),
    .nextCRC16_D64 (calc_crc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      is_setup_q    <= 1'b0;
      cnt_q         <= '0;
      pkt_q         <= '0;
      toggle_q      <= 1'b0;
      hs_valid_q    <= 1'b0;
      hs_pid_q      <= 8'h00;
      buf_wr_q      <= 1'b0;
      buf_data_q    <= 64'h0;
      setup_valid_q <= 1'b0;
      setup_data_q  <= 64'h0;
      data_error_q  <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      is_setup_q    <= is_setup_d;
      cnt_q         <= cnt_d;
      pkt_q         <= pkt_d;
      toggle_q      <= toggle_d;
      hs_valid_q    <= hs_valid_d;
      hs_pid_q      <= hs_pid_d;
      buf_wr_q      <= buf_wr_d;
      buf_data_q    <= buf_data_d;
      setup_valid_q <= setup_valid_d;
      setup_data_q  <= setup_data_d;
      data_error_q  <= data_error_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    is_setup_d    = is_setup_q;
    cnt_d         = cnt_q;
    pkt_d         = pkt_q;
    toggle_d      = toggle_q;
    hs_valid_d    = 1'b0;
    hs_pid_d      = hs_pid_q;
    buf_wr_d      = 1'b0;
    buf_data_d    = buf_data_q;
    setup_valid_d = 1'b0;
    setup_data_d  = setup_data_q;
    data_error_d  = 1'b0;
    timeout_err_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.token_valid &&
            (bus.token_pid == PID_SETUP || bus.token_pid == PID_OUT)) begin
          is_setup_d = (bus.token_pid == PID_SETUP);
          cnt_d      = '0;
          state_d    = ST_WAIT_DATA;
          if (bus.token_pid == PID_SETUP) toggle_d = 1'b0;
        end
      end

      ST_WAIT_DATA: begin
        cnt_d = cnt_q + 1'b1;
        // A packet arriving on the last allowed cycle still counts.
        if (bus.pkt_valid) begin
          pkt_d   = bus.packet[87:0];
          state_d = ST_CHECK;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          timeout_err_d = 1'b1;
          state_d       = ST_IDLE;
        end
      end

      ST_CHECK: begin
        if (!pid_is_data(rx_pid) || (calc_crc != rx_crc)) begin
          data_error_d = 1'b1;
          state_d      = ST_IDLE;
        end else begin
          hs_valid_d = 1'b1;
          state_d    = ST_HANDSHAKE;
          if (!is_setup_q && bus.ep_stall) begin
            hs_pid_d = PID_STALL;
          end else if (rx_toggle != toggle_q) begin
            // Retransmission of a packet already taken: ack it, drop the data.
            hs_pid_d = PID_ACK;
          end else if (is_setup_q) begin
            setup_data_d  = rx_payload;
            setup_valid_d = 1'b1;
            toggle_d      = 1'b1;
            hs_pid_d      = PID_ACK;
          end else if (!bus.buf_ready) begin
            hs_pid_d = PID_NAK;
          end else begin
            buf_data_d = rx_payload;
            buf_wr_d   = 1'b1;
            toggle_d   = ~toggle_q;
            hs_pid_d   = PID_ACK;
          end
        end
      end

      ST_HANDSHAKE: begin
        hs_valid_d = ~bus.hs_ready;
        if (bus.hs_ready) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.buf_wr      = buf_wr_q;
  assign bus.buf_data    = buf_data_q;
  assign bus.setup_valid = setup_valid_q;
  assign bus.setup_data  = setup_data_q;
  assign bus.hs_valid    = hs_valid_q;
  assign bus.hs_pid      = hs_pid_q;
  assign bus.data_error  = data_error_q;
  assign bus.timeout_err = timeout_err_q;
  assign bus.toggle      = toggle_q;
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.state       = state_q;

endmodule

// File: doc/ep_out_txn_ctrl.md
# ep_out_txn_ctrl

Receive-side transaction controller for a single endpoint. It sequences one host-to-device transaction: SETUP/OUT token, then DATA0/DATA1 packet, then CRC16 check, then data-toggle check, then buffer write, then ACK/NAK/STALL handshake. The block sits between the packet deserializer and the endpoint data buffer. It owns the endpoint's data-toggle bit and its handshake generation.

## Interface
Parameters:
- TIMEOUT, 32: cycles allowed in WAIT_DATA before the transaction is abandoned.
- CRC_INIT, 16'h0000: CRC16 seed.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- token_valid  in  1  token strobe; the token is already address/endpoint matched.
- token_pid  in  8  token PID; SETUP=8'h2D, OUT=8'hE1, all others ignored.
- pkt_valid  in  1  data-packet strobe.
- packet  in  89  [88] reserved and ignored; [87:80] PID; [79:16] payload; [15:0] CRC16.
- ep_stall  in  1  endpoint halted; OUT tokens are answered with STALL.
- buf_ready  in  1  endpoint buffer can accept one 64-bit word.
- buf_wr  out  1  one-cycle write strobe for the OUT payload.
- buf_data  out  64  OUT payload.
- setup_valid  out  1  one-cycle strobe for the SETUP payload.
- setup_data  out  64  SETUP payload.
- hs_valid  out  1  handshake request.
- hs_pid  out  8  ACK=8'hD2, NAK=8'h5A, STALL=8'h1E.
- hs_ready  in  1  handshake accepted by the transmitter.
- data_error  out  1  one-cycle pulse on a bad PID or a CRC mismatch.
- timeout_err  out  1  one-cycle pulse when WAIT_DATA times out.
- toggle  out  1  expected DATA PID: 0 means DATA0 (8'hC3), 1 means DATA1 (8'h4B).
- busy  out  1  high whenever the state is not IDLE.

## Operation
- States: IDLE, WAIT_DATA, CHECK, HANDSHAKE.
- IDLE:
  - token_valid with SETUP or OUT latches the token kind, clears the timeout counter, and moves to WAIT_DATA.
  - SETUP forces toggle to 0.
  - Other PIDs are ignored.
  - pkt_valid is ignored.
- WAIT_DATA:
  - The counter increments every cycle.
  - pkt_valid registers packet and moves to CHECK.
  - If the counter reaches TIMEOUT-1 without pkt_valid: pulse timeout_err, return to IDLE, no handshake.
  - If pkt_valid and timeout occur in the same cycle, the packet wins.
  - token_valid is ignored in every non-IDLE state.
- CHECK is one cycle. The CRC is computed over the registered payload with seed CRC_INIT. Resolve in priority order:
  1. PID is neither DATA0 nor DATA1, or CRC != packet[15:0]: pulse data_error, go to IDLE, no handshake, toggle unchanged.
  2. OUT with ep_stall=1: handshake STALL.
  3. PID toggle bit != toggle (duplicate packet): handshake ACK, no write, toggle unchanged.
  4. SETUP: load setup_data, pulse setup_valid, flip toggle to 1, handshake ACK. buf_ready and ep_stall are ignored for SETUP.
  5. OUT with buf_ready=0: handshake NAK, no write, toggle unchanged.
  6. OUT with buf_ready=1: load buf_data, pulse buf_wr, flip toggle, handshake ACK.
- HANDSHAKE:
  - hs_valid=1 and hs_pid are held stable until hs_ready.
  - In the cycle hs_ready=1, return to IDLE.
- Reset values: state IDLE, toggle 0, and all strobes, hs_valid and busy 0. hs_pid, buf_data and setup_data are 0. Reset asserted mid-transaction abandons the transaction without a handshake.

## Timing
- Every output is registered.
- pkt_valid at cycle T means CHECK is active at T+1.
- buf_wr/setup_valid/data_error and the first cycle of hs_valid all appear at T+2.
- An updated toggle is visible at T+2.
- Minimum transaction length: token at T0, packet at T0+1, handshake accepted at T0+3, IDLE at T0+4.
- A new token is accepted in the first IDLE cycle.
- Timeout: a token at T0 with no packet produces timeout_err at T0+TIMEOUT+1 (registered), with IDLE at the same cycle.

## Structure
- Shared package ep_pkg holds:
  - PID constants: SETUP, OUT, DATA0, DATA1, ACK, NAK, STALL.
  - Packet field bit positions.
  - The state enumeration.
- One sub-module: CRC16_D64, the existing combinational CRC16 over 64 bits (Data, crc, nextCRC16_D64). It is instantiated once and fed the registered payload and CRC_INIT.

## Test plan
- Reset, then SETUP followed by DATA0 with a good CRC and payload 64'h0123_4567_89AB_CDEF: setup_valid pulses with that data, hs_pid=8'hD2, toggle becomes 1.
- OUT followed by DATA1 (good CRC, buf_ready=1), then OUT followed by DATA0: two buf_wr pulses, two ACKs, toggle ends at 1. Repeating the DATA0 packet gives ACK with no buf_wr.
- OUT followed by a packet whose CRC has bit 0 flipped: data_error pulses, no hs_valid, no write, toggle unchanged.
- OUT with buf_ready=0: NAK and no write. The same OUT with ep_stall=1: STALL. SETUP with ep_stall=1: ACK.
- OUT, then no packet for TIMEOUT=32 cycles: timeout_err at T0+33, busy drops. A packet arriving on the timeout cycle is processed normally.
- hs_ready held low for 5 cycles: hs_valid and hs_pid stay stable. Reset asserted during HANDSHAKE: IDLE next cycle, toggle=0, hs_valid=0.
